// File: rtl/sram_la_checker_pkg.sv
// Shared definitions for the SRAM latency-aware checker: command encodings,
// controller state types and a small saturating-counter helper.
package sram_la_checker_pkg;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_SWEEP = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_CHECK,
    ST_DONE
  } state_t;

  typedef enum logic {
    PH_WR,
    PH_RD
  } sweep_phase_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/sram_la_checker_cmp.sv
// Masked byte comparator: passes when every byte selected by the mask matches.
// An all-zero mask selects nothing and therefore always passes.
module sram_la_cmp #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]   i_expected,
  input  logic [DATA_W-1:0]   i_actual,
  input  logic [DATA_W/8-1:0] i_mask,
  output logic                o_pass
);

  // Walk the bytes and drop the pass flag on any selected byte that differs.
  always_comb begin
    o_pass = 1'b1;
    for (int b = 0; b < DATA_W / 8; b++) begin
      if (i_mask[b] && (i_expected[8*b +: 8] != i_actual[8*b +: 8])) begin
        o_pass = 1'b0;
      end
    end
  end

endmodule

// File: rtl/sram_la_checker.sv
// SRAM checker: accepts write / read-check / sweep / clear-status commands,
// drives a synchronous SRAM port and records the first failing access.
module sram_la_checker
  import sram_la_checker_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_data,
  input  logic [DATA_W/8-1:0] cmd_mask,
  output logic                sram_csb,
  output logic                sram_web,
  output logic [DATA_W/8-1:0] sram_wmask,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [DATA_W-1:0]   sram_din,
  input  logic [DATA_W-1:0]   sram_dout,
  output logic                busy,
  output logic                done,
  output logic                mismatch,
  output logic [ADDR_W-1:0]   err_addr,
  output logic [DATA_W-1:0]   err_data,
  output logic [15:0]         chk_cnt
);

  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_MAX  = '1;
  localparam logic [1:0]        WAIT_LAST = 2'(RD_LAT - 1);

  state_t              r_state;
  sweep_phase_t        r_phase;
  logic [1:0]          r_op;
  logic [DATA_W-1:0]   r_data;
  logic [DATA_W/8-1:0] r_mask;
  logic [1:0]          r_wait;
  logic                r_csb;
  logic                r_web;
  logic [DATA_W/8-1:0] r_wmask;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_din;
  logic                r_done;
  logic                r_mismatch;
  logic [ADDR_W-1:0]   r_err_addr;
  logic [DATA_W-1:0]   r_err_data;
  logic [15:0]         r_chk_cnt;

  logic                w_is_sweep;
  logic                w_last_addr;
  logic [ADDR_W-1:0]   w_next_addr;
  logic [DATA_W-1:0]   w_exp_data;
  logic [DATA_W/8-1:0] w_exp_mask;
  logic                w_pass;

  // Sweeps expect seed + address with every byte compared; read-checks use the latched fields.
  assign w_is_sweep  = (r_op == OP_SWEEP);
  assign w_last_addr = (r_addr == ADDR_MAX);
  assign w_next_addr = r_addr + ADDR_ONE;
  assign w_exp_data  = w_is_sweep ? (r_data + DATA_W'(r_addr)) : r_data;
  assign w_exp_mask  = w_is_sweep ? '1 : r_mask;

  sram_la_cmp #(.DATA_W(DATA_W)) u_cmp (
    .i_expected (w_exp_data),
    .i_actual   (sram_dout),
    .i_mask     (w_exp_mask),
    .o_pass     (w_pass)
  );

  // Controller FSM with registered SRAM strobes, done pulse and status.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= ST_IDLE;
      r_phase    <= PH_WR;
      r_op       <= OP_WRITE;
      r_data     <= '0;
      r_mask     <= '0;
      r_wait     <= '0;
      r_csb      <= 1'b1;
      r_web      <= 1'b1;
      r_wmask    <= '0;
      r_addr     <= '0;
      r_din      <= '0;
      r_done     <= 1'b0;
      r_mismatch <= 1'b0;
      r_err_addr <= '0;
      r_err_data <= '0;
      r_chk_cnt  <= '0;
    end else begin
      r_csb  <= 1'b1;
      r_web  <= 1'b1;
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_op   <= cmd_op;
            r_data <= cmd_data;
            r_mask <= cmd_mask;
            case (cmd_op)
              OP_WRITE: begin
                r_state <= ST_ISSUE;
                r_csb   <= 1'b0;
                r_web   <= 1'b0;
                r_addr  <= cmd_addr;
                r_din   <= cmd_data;
                r_wmask <= cmd_mask;
              end
              OP_READ: begin
                r_state <= ST_ISSUE;
                r_csb   <= 1'b0;
                r_addr  <= cmd_addr;
              end
              OP_SWEEP: begin
                r_state <= ST_ISSUE;
                r_phase <= PH_WR;
                r_csb   <= 1'b0;
                r_web   <= 1'b0;
                r_addr  <= '0;
                r_din   <= cmd_data;
                r_wmask <= '1;
              end
              default: begin
                r_state    <= ST_DONE;
                r_done     <= 1'b1;
                r_mismatch <= 1'b0;
                r_err_addr <= '0;
                r_err_data <= '0;
                r_chk_cnt  <= '0;
              end
            endcase
          end
        end
        ST_ISSUE: begin
          if (r_op == OP_WRITE) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end else if (w_is_sweep && (r_phase == PH_WR)) begin
            r_csb <= 1'b0;
            if (w_last_addr) begin
              r_phase <= PH_RD;
              r_addr  <= '0;
            end else begin
              r_web  <= 1'b0;
              r_addr <= w_next_addr;
              r_din  <= r_data + DATA_W'(w_next_addr);
            end
          end else begin
            r_state <= ST_WAIT;
            r_wait  <= '0;
          end
        end
        ST_WAIT: begin
          if (r_wait == WAIT_LAST) begin
            r_state <= ST_CHECK;
          end else begin
            r_wait <= r_wait + 2'd1;
          end
        end
        ST_CHECK: begin
          r_chk_cnt <= sat_inc16(r_chk_cnt);
          if (!w_pass) begin
            r_mismatch <= 1'b1;
            if (!r_mismatch) begin
              r_err_addr <= r_addr;
              r_err_data <= sram_dout;
            end
          end
          if (w_is_sweep && !w_last_addr) begin
            r_state <= ST_ISSUE;
            r_csb   <= 1'b0;
            r_addr  <= w_next_addr;
          end else begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready  = (r_state == ST_IDLE);
  assign busy       = (r_state != ST_IDLE);
  assign done       = r_done;
  assign sram_csb   = r_csb;
  assign sram_web   = r_web;
  assign sram_wmask = r_wmask;
  assign sram_addr  = r_addr;
  assign sram_din   = r_din;
  assign mismatch   = r_mismatch;
  assign err_addr   = r_err_addr;
  assign err_data   = r_err_data;
  assign chk_cnt    = r_chk_cnt;

endmodule
